// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide engine.
//   - Op encodings for MULT/MULTU/DIV/DIVU
//   - FSM state encoding
//   - iteration count and counter width
//   - small decode helpers for the Op field
package muldiv_pkg;

  localparam int MULDIV_ITER = 32;
  localparam int CNT_W       = $clog2(MULDIV_ITER);

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } stateT;

  function automatic logic isDivOp(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic isSignedOp(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_negate64.sv
// muldiv_negate64: conditional two's-complement negation of a 64-bit word.
// Ports:
//   Negate  in  1  : when high, DataOut = -DataIn, otherwise DataOut = DataIn
//   DataIn  in  64 : value to condition
//   DataOut out 64 : conditioned value
module muldiv_negate64 (
  input  logic        Negate,
  input  logic [63:0] DataIn,
  output logic [63:0] DataOut
);

  assign DataOut = Negate ? (~DataIn + 64'd1) : DataIn;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit MULT/MULTU/DIV/DIVU engine feeding Hi/Lo.
// A Start accepted in IDLE runs 32 CALC iterations and one FIX cycle; the
// result and a one-cycle Done/HiLoWrite pulse appear 33 cycles after Start.
// Busy stays high from the Start edge until the cycle after Done.
// Optional feature macro: MULDIV_ABORT_EN adds the Abort (pipeline flush) port.
// Ports:
//   Clk       in  1  : rising-edge clock
//   Reset     in  1  : asynchronous active-low reset
//   Start     in  1  : request strobe, honoured only when idle and not busy
//   Op        in  2  : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   OperandA  in  32 : multiplicand / dividend
//   OperandB  in  32 : multiplier / divisor
//   Abort     in  1  : kill in-flight operation (MULDIV_ABORT_EN only)
//   Busy      out 1  : operation in flight
//   Done      out 1  : one-cycle completion pulse
//   HiLoWrite out 1  : Hi/Lo write enable (same as Done)
//   HiOut     out 32 : product[63:32] or remainder, held until next Done
//   LoOut     out 32 : product[31:0] or quotient, held until next Done
//   DivZero   out 1  : divide had a zero divisor, held with the result
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] OperandA,
  input  logic [31:0] OperandB,
`ifdef MULDIV_ABORT_EN
  input  logic        Abort,
`endif
  output logic        Busy,
  output logic        Done,
  output logic        HiLoWrite,
  output logic [31:0] HiOut,
  output logic [31:0] LoOut,
  output logic        DivZero
);

  logic abortHit;
`ifdef MULDIV_ABORT_EN
  assign abortHit = Abort;
`else
  assign abortHit = 1'b0;
`endif

  // Control state
  stateT              state, nextState;
  logic [CNT_W-1:0]   count;
  logic               busyR, doneR, divZeroR;
  logic [31:0]        hiR, loR;
  logic               accept, step, finish;

  // Datapath state (no reset: only meaningful after a Start is accepted)
  logic [1:0]         opR;
  logic               signQ, signR, dzPend;
  logic [31:0]        operandR;   // multiplicand for multiply, divisor for divide
  logic [31:0]        rawA;
  logic [63:0]        acc;        // {upper, lower}: product or {remainder, dividend/quotient}

  // Operand magnitudes
  logic [63:0] negAOut, negBOut;
  logic [31:0] magA, magB;
  logic [31:0] unusedMagAHi, unusedMagBHi;
  logic        startSigned;

  assign startSigned = isSignedOp(Op);

  muldiv_negate64 uNegA (
    .Negate  (startSigned & OperandA[31]),
    .DataIn  ({32'd0, OperandA}),
    .DataOut (negAOut)
  );

  muldiv_negate64 uNegB (
    .Negate  (startSigned & OperandB[31]),
    .DataIn  ({32'd0, OperandB}),
    .DataOut (negBOut)
  );

  assign {unusedMagAHi, magA} = negAOut;
  assign {unusedMagBHi, magB} = negBOut;

  // Multiply step: 33-bit add into the upper half keeps the carry, which
  // becomes the top bit after the right shift.
  logic [32:0] mulSum;
  logic [63:0] mulNext;
  assign mulSum  = {1'b0, acc[63:32]} + {1'b0, operandR};
  assign mulNext = acc[0] ? {mulSum, acc[31:1]} : {1'b0, acc[63:1]};

  // Divide step: the shifted partial remainder can reach 33 bits, so the
  // trial subtract carries an extra borrow bit to get a reliable sign.
  logic [32:0] remShift;
  logic [33:0] trial;
  logic        trialNeg, unusedTrialBit;
  logic [31:0] trialRem;
  logic [63:0] divNext;
  assign remShift = {acc[63:32], acc[31]};
  assign trial    = {1'b0, remShift} - {2'b00, operandR};
  assign {trialNeg, unusedTrialBit, trialRem} = trial;
  assign divNext  = trialNeg ? {remShift[31:0], acc[30:0], 1'b0}
                             : {trialRem,       acc[30:0], 1'b1};

  // Sign fix. The low word of a 64-bit negate equals the negated low word,
  // so one instance serves both the product and the quotient.
  logic [63:0] fixProd, fixRemFull;
  logic [31:0] fixRem, unusedRemHi;

  muldiv_negate64 uNegProd (
    .Negate  (signQ),
    .DataIn  (acc),
    .DataOut (fixProd)
  );

  muldiv_negate64 uNegRem (
    .Negate  (signR),
    .DataIn  ({32'd0, acc[63:32]}),
    .DataOut (fixRemFull)
  );

  assign {unusedRemHi, fixRem} = fixRemFull;

  logic [31:0] resHi, resLo;
  logic        resDz;

  always_comb begin
    resHi = fixProd[63:32];
    resLo = fixProd[31:0];
    resDz = 1'b0;
    if (dzPend) begin
      // Zero divisor: fixed quotient pattern, raw dividend as remainder.
      resHi = rawA;
      resLo = 32'hFFFF_FFFF;
      resDz = 1'b1;
    end else if (isDivOp(opR)) begin
      resHi = fixRem;
      resLo = fixProd[31:0];
    end
  end

  // FSM next state
  always_comb begin
    nextState = state;
    accept    = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE: begin
        // busyR is still high in the Done cycle; a Start there is dropped.
        if (Start && !busyR && !abortHit) begin
          accept    = 1'b1;
          nextState = ST_CALC;
        end
      end
      ST_CALC: begin
        step = 1'b1;
        if (abortHit)
          nextState = ST_IDLE;
        else if (count == CNT_W'(MULDIV_ITER - 1))
          nextState = ST_FIX;
      end
      ST_FIX: begin
        nextState = ST_IDLE;
        if (!abortHit)
          finish = 1'b1;
      end
      default: nextState = ST_IDLE;
    endcase
  end

  // Control registers and result outputs
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= ST_IDLE;
      count    <= '0;
      busyR    <= 1'b0;
      doneR    <= 1'b0;
      hiR      <= '0;
      loR      <= '0;
      divZeroR <= 1'b0;
    end else begin
      state <= nextState;
      doneR <= finish;

      if (state == ST_CALC && nextState == ST_CALC)
        count <= count + CNT_W'(1);
      else
        count <= '0;

      if (accept)
        busyR <= 1'b1;
      else if (abortHit && state != ST_IDLE)
        busyR <= 1'b0;
      else if (doneR)
        busyR <= 1'b0;

      if (finish) begin
        hiR      <= resHi;
        loR      <= resLo;
        divZeroR <= resDz;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge Clk) begin
    if (accept) begin
      opR      <= Op;
      signQ    <= startSigned & (OperandA[31] ^ OperandB[31]);
      signR    <= startSigned & OperandA[31];
      dzPend   <= isDivOp(Op) && (OperandB == 32'd0);
      rawA     <= OperandA;
      operandR <= isDivOp(Op) ? magB : magA;
      acc      <= isDivOp(Op) ? {32'd0, magA} : {32'd0, magB};
    end else if (step) begin
      acc <= isDivOp(opR) ? divNext : mulNext;
    end
  end

  assign Busy      = busyR;
  assign Done      = doneR;
  assign HiLoWrite = doneR;
  assign HiOut     = hiR;
  assign LoOut     = loR;
  assign DivZero   = divZeroR;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
// Exercises MULT/MULTU/DIV/DIVU with hand-computed results, divide by zero,
// the signed boundary cases, ignored Start requests, reset mid-operation,
// and (with MULDIV_ABORT_EN) the Abort flush.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] OperandA, OperandB;
`ifdef MULDIV_ABORT_EN
  logic        Abort;
`endif
  logic        Busy, Done, HiLoWrite, DivZero;
  logic [31:0] HiOut, LoOut;

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  muldiv_unit dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Op        (Op),
    .OperandA  (OperandA),
    .OperandB  (OperandB),
`ifdef MULDIV_ABORT_EN
    .Abort     (Abort),
`endif
    .Busy      (Busy),
    .Done      (Done),
    .HiLoWrite (HiLoWrite),
    .HiOut     (HiOut),
    .LoOut     (LoOut),
    .DivZero   (DivZero)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle, then scramble the operand inputs.
  // Returns in the first cycle after the Start edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge Clk);
    Start = 1'b1; Op = op; OperandA = a; OperandB = b;
    @(negedge Clk);
    Start = 1'b0;
    Op = 2'($urandom); OperandA = $urandom; OperandB = $urandom;
  endtask

  task automatic runOp(input string tag, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expHi, input logic [31:0] expLo,
                       input logic expDz);
    int cyc;
    issue(op, a, b);
    check({tag, " busy_after_start"}, Busy, 1);
    cyc = 0;
    while (Done !== 1'b1 && cyc < 40) begin
      @(negedge Clk);
      cyc++;
    end
    check({tag, " latency"}, cyc, 33);
    check({tag, " hi"}, HiOut, expHi);
    check({tag, " lo"}, LoOut, expLo);
    check({tag, " divzero"}, DivZero, expDz);
    check({tag, " hilowrite"}, HiLoWrite, 1);
    check({tag, " busy_in_done"}, Busy, 1);
    @(negedge Clk);
    check({tag, " done_drop"}, Done, 0);
    check({tag, " busy_drop"}, Busy, 0);
  endtask

  int doneCnt, doneCyc, busyLowCyc;

  initial begin
    Reset = 1'b0; Start = 1'b0; Op = 2'b00; OperandA = '0; OperandB = '0;
`ifdef MULDIV_ABORT_EN
    Abort = 1'b0;
`endif
    #2;
    check("reset busy", Busy, 0);
    check("reset done", Done, 0);
    check("reset hilowrite", HiLoWrite, 0);
    check("reset hi", HiOut, 0);
    check("reset lo", LoOut, 0);
    check("reset divzero", DivZero, 0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;

    runOp("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    runOp("mult_neg",  OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    runOp("div_neg",   OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    runOp("divu",      OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0);
    runOp("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0);
    runOp("divu_zero", OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1);
    runOp("div_zero",  OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
    runOp("mult_min",  OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0);

    // Start while busy, in FIX and in the Done cycle must all be dropped.
    issue(OP_MULTU, 32'd3, 32'd5);
    doneCnt = 0; doneCyc = -1; busyLowCyc = -1;
    for (int c = 0; c <= 40; c++) begin
      if (Done === 1'b1) begin doneCnt++; doneCyc = c; end
      if (Busy !== 1'b1 && busyLowCyc < 0) busyLowCyc = c;
      case (c)
        10: begin Start = 1'b1; Op = OP_DIVU; OperandA = 32'd9; OperandB = 32'd3; end
        11: Start = 1'b0;
        32: begin Start = 1'b1; Op = OP_MULT; OperandA = 32'd2; OperandB = 32'd2; end
        34: Start = 1'b0;
        default: ;
      endcase
      @(negedge Clk);
    end
    check("ignore done_count", doneCnt, 1);
    check("ignore done_cycle", doneCyc, 33);
    check("ignore busy_fall", busyLowCyc, 34);
    check("ignore lo", LoOut, 32'd15);
    check("ignore hi", HiOut, 32'd0);
    check("ignore busy_end", Busy, 0);

    // Reset mid-operation clears everything without waiting for a clock.
    issue(OP_MULTU, 32'h1234_5678, 32'd9);
    for (int c = 0; c < 15; c++) @(negedge Clk);
    Reset = 1'b0;
    #1;
    check("midreset busy", Busy, 0);
    check("midreset done", Done, 0);
    check("midreset hilowrite", HiLoWrite, 0);
    check("midreset hi", HiOut, 0);
    check("midreset lo", LoOut, 0);
    check("midreset divzero", DivZero, 0);
    @(negedge Clk);
    Reset = 1'b1;
    doneCnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (HiLoWrite === 1'b1) doneCnt++;
      @(negedge Clk);
    end
    check("midreset no_write", doneCnt, 0);
    check("midreset lo_after", LoOut, 0);

`ifdef MULDIV_ABORT_EN
    runOp("pre_abort", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    issue(OP_MULTU, 32'd7, 32'd7);
    for (int c = 0; c < 20; c++) @(negedge Clk);
    Abort = 1'b1;
    @(negedge Clk);
    Abort = 1'b0;
    check("abort busy", Busy, 0);
    doneCnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (Done === 1'b1) doneCnt++;
      @(negedge Clk);
    end
    check("abort no_done", doneCnt, 0);
    check("abort hi_kept", HiOut, 32'd2);
    check("abort lo_kept", LoOut, 32'd14);
    Start = 1'b1; Abort = 1'b1; Op = OP_MULTU; OperandA = 32'd1; OperandB = 32'd1;
    @(negedge Clk);
    Start = 1'b0; Abort = 1'b0;
    check("abort_over_start busy", Busy, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
